// File: rtl/fifo_thresh.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky error flags
// and a selectable registered or first-word-fall-through read port.
module fifo_thresh #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 1,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0] DepthCnt = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AfCnt    = (PTR_WIDTH + 1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AeCnt    = (PTR_WIDTH + 1)'(AE_THRESH);
  localparam logic [PTR_WIDTH:0] PtrOne   = (PTR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               rd_acc, wr_acc;

  // Status comes only from registered pointers; the extra wrap bit disambiguates full/empty.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == DepthCnt);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AfCnt);
  assign almost_empty = (count <= AeCnt);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read on a full FIFO frees a slot, so a same-cycle write is accepted too.
  assign rd_acc = read_en && !empty;
  assign wr_acc = write_en && (!full || read_en);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    // A new error in the clearing cycle wins.
    if (write_en && !wr_acc) overflow_d = 1'b1;
    if (read_en && !rd_acc) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_q[PTR_WIDTH-1:0]] <= write_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign read_data = mem[rd_ptr_q[PTR_WIDTH-1:0]];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] read_data_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        read_data_q <= '0;
      end else if (rd_acc) begin
        read_data_q <= mem[rd_ptr_q[PTR_WIDTH-1:0]];
      end
    end
    assign read_data = read_data_q;
  end

endmodule
